riscv_core_dmem_resp_queue: RTL and testbench

- Parametrised N-entry data-memory response queue with subword load extraction, for the long-pipeline core's M stage.
- Captures dmem responses while later stages stall, then releases them in order to the writeback mux.
- Extends the existing single-register queue and subword mux with:
  - configurable depth and data width
  - byte-offset lane selection
  - explicit val/rdy handshakes
  - occupancy reporting and flush

---
 rtl/riscv_core_dmem_pkg.sv | 18 +
 rtl/riscv_core_dmem_resp_queue_if.sv | 28 ++
 rtl/riscv_core_dmem_subword_extract.sv | 39 +++
 rtl/riscv_core_dmem_resp_queue.sv | 93 +++++++++
 tb/tb_riscv_core_dmem_resp_queue.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/riscv_core_dmem_pkg.sv
// rtl/riscv_core_dmem_pkg.sv - dmem load type codes and offset-width helper
package riscv_core_dmem_pkg;

  typedef enum logic [2:0] {
    DMEM_TYPE_W   = 3'd0,
    DMEM_TYPE_LB  = 3'd1,
    DMEM_TYPE_LBU = 3'd2,
    DMEM_TYPE_LH  = 3'd3,
    DMEM_TYPE_LHU = 3'd4
  } dmem_type_e;

  localparam int DMEM_TYPE_BITS = 3;

  function automatic int dmem_off_w(input int data_w);
    return $clog2(data_w / 8);
  endfunction

endpackage

// File: rtl/riscv_core_dmem_resp_queue_if.sv
// rtl/riscv_core_dmem_resp_queue_if.sv - enq/deq val/rdy bundle for the dmem response queue
interface riscv_core_dmem_resp_queue_if #(
  parameter int DATA_W = 32
);
  import riscv_core_dmem_pkg::*;

  localparam int OFF_W = dmem_off_w(DATA_W);

  logic                      enq_val;
  logic                      enq_rdy;
  logic [DATA_W-1:0]         enq_msg_data;
  logic [DMEM_TYPE_BITS-1:0] enq_msg_type;
  logic [OFF_W-1:0]          enq_msg_offset;
  logic                      deq_val;
  logic                      deq_rdy;
  logic [DATA_W-1:0]         deq_msg_data;

  modport master (
    output enq_val, enq_msg_data, enq_msg_type, enq_msg_offset, deq_rdy,
    input  enq_rdy, deq_val, deq_msg_data
  );

  modport slave (
    input  enq_val, enq_msg_data, enq_msg_type, enq_msg_offset, deq_rdy,
    output enq_rdy, deq_val, deq_msg_data
  );

endinterface

// File: rtl/riscv_core_dmem_subword_extract.sv
// rtl/riscv_core_dmem_subword_extract.sv - byte/halfword lane select with sign/zero extension
module riscv_core_dmem_subword_extract
  import riscv_core_dmem_pkg::*;
#(
  parameter int DATA_W = 32,
  localparam int OFF_W = dmem_off_w(DATA_W)
) (
  input  logic [DATA_W-1:0]         data,
  input  logic [DMEM_TYPE_BITS-1:0] msg_type,
  input  logic [OFF_W-1:0]          offset,
  output logic [DATA_W-1:0]         ext_data
);

  logic [DATA_W-1:0] byte_shift;
  logic [DATA_W-1:0] half_shift;
  logic [7:0]        byte_v;
  logic [15:0]       half_v;

  // Halfword lanes ignore offset[0]; the shift amount drops that bit.
  always_comb begin
    byte_shift = data >> {offset, 3'b000};
    half_shift = data >> {offset[OFF_W-1:1], 4'b0000};
    byte_v     = byte_shift[7:0];
    half_v     = half_shift[15:0];
  end

  always_comb begin
    ext_data = '0;
    case (msg_type)
      DMEM_TYPE_W:   ext_data = data;
      DMEM_TYPE_LB:  ext_data = {{(DATA_W-8){byte_v[7]}}, byte_v};
      DMEM_TYPE_LBU: ext_data = {{(DATA_W-8){1'b0}}, byte_v};
      DMEM_TYPE_LH:  ext_data = {{(DATA_W-16){half_v[15]}}, half_v};
      DMEM_TYPE_LHU: ext_data = {{(DATA_W-16){1'b0}}, half_v};
      default:       ext_data = '0;
    endcase
  end

endmodule

// File: rtl/riscv_core_dmem_resp_queue.sv
// rtl/riscv_core_dmem_resp_queue.sv - N-entry dmem response queue, extraction before storage; RISCV_DMEMQ_BYPASS_EN adds empty-queue pass-through
module riscv_core_dmem_resp_queue
  import riscv_core_dmem_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        flush,
  riscv_core_dmem_resp_queue_if.slave q,
  output logic [CNT_W-1:0]            count
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;

  logic [DATA_W-1:0] ext_data;
  logic              not_empty;
  logic              bypass;
  logic              do_write;
  logic              do_read;

  riscv_core_dmem_subword_extract #(
    .DATA_W (DATA_W)
  ) u_extract (
    .data     (q.enq_msg_data),
    .msg_type (q.enq_msg_type),
    .offset   (q.enq_msg_offset),
    .ext_data (ext_data)
  );

  assign not_empty = (count_q != '0);

`ifdef RISCV_DMEMQ_BYPASS_EN
  // Gated by reset so an asserted reset never shows a passing response.
  assign bypass = reset && !flush && q.enq_val && !not_empty;
`else
  assign bypass = 1'b0;
`endif

  assign q.enq_rdy      = (count_q != CNT_W'(DEPTH));
  assign q.deq_val      = not_empty || bypass;
  assign q.deq_msg_data = not_empty ? mem_q[rd_ptr_q] : (bypass ? ext_data : '0);
  assign count          = count_q;

  assign do_write = q.enq_val && q.enq_rdy && !(bypass && q.deq_rdy);
  assign do_read  = not_empty && q.deq_rdy;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      count_d  = '0;
      wr_ptr_d = rd_ptr_q;
    end else begin
      if (do_write) begin
        mem_d[wr_ptr_q] = ext_data;
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (do_read) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({do_write, do_read})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: tb/tb_riscv_core_dmem_resp_queue.sv
// tb/tb_riscv_core_dmem_resp_queue.sv - directed scoreboard bench for the dmem response queue
module tb_riscv_core_dmem_resp_queue;

  logic       clk;
  logic       reset;
  logic       flush;
  logic [2:0] count;

  int tests_run    = 0;
  int tests_failed = 0;
  logic [31:0] exp_q [$];

  riscv_core_dmem_resp_queue_if #(.DATA_W(32)) bus ();

  riscv_core_dmem_resp_queue #(
    .DATA_W (32),
    .DEPTH  (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .q     (bus),
    .count (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic set_enq(input logic v, input logic [31:0] d, input logic [2:0] t, input logic [1:0] o);
    bus.enq_val        = v;
    bus.enq_msg_data   = d;
    bus.enq_msg_type   = t;
    bus.enq_msg_offset = o;
  endtask

  // Scoreboard: every accepted dequeue must match the oldest expected value.
  always @(negedge clk) begin
    if (reset && !flush && bus.deq_val && bus.deq_rdy) begin
      tests_run++;
      assert (exp_q.size() != 0) else begin
        tests_failed++;
        $error("FAIL unexpected_deq: observed %h expected no output", bus.deq_msg_data);
      end
      if (exp_q.size() != 0) begin
        tests_run--;
        check("deq_data", {32'h0, bus.deq_msg_data}, {32'h0, exp_q.pop_front()});
      end
    end
  end

  initial begin
    reset = 1'b0;
    flush = 1'b0;
    bus.deq_rdy = 1'b0;
    set_enq(1'b0, 32'h0, 3'd0, 2'd0);

    #3;
    check("rst_deq_val", {63'h0, bus.deq_val}, 64'h0);
    check("rst_enq_rdy", {63'h0, bus.enq_rdy}, 64'h1);
    check("rst_count", {61'h0, count}, 64'h0);
    check("rst_deq_data", {32'h0, bus.deq_msg_data}, 64'h0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    next();

    // Subword extraction, drained as produced
    bus.deq_rdy = 1'b1;
    set_enq(1'b1, 32'h80FF7F01, 3'd1, 2'd3); exp_q.push_back(32'hFFFFFF80); next();
    set_enq(1'b1, 32'h80FF7F01, 3'd2, 2'd3); exp_q.push_back(32'h00000080); next();
    set_enq(1'b1, 32'h80FF7F01, 3'd3, 2'd2); exp_q.push_back(32'hFFFF80FF); next();
    set_enq(1'b1, 32'h80FF7F01, 3'd4, 2'd1); exp_q.push_back(32'h00007F01); next();
    set_enq(1'b1, 32'h80FF7F01, 3'd4, 2'd2); exp_q.push_back(32'h000080FF); next();
    set_enq(1'b1, 32'h80FF7F01, 3'd6, 2'd0); exp_q.push_back(32'h00000000); next();
    set_enq(1'b1, 32'h80FF7F01, 3'd0, 2'd3); exp_q.push_back(32'h80FF7F01); next();
    set_enq(1'b0, 32'h0, 3'd0, 2'd0);
    next(); next();
    check("extract_drained", 64'(exp_q.size()), 64'h0);
    check("extract_count", {61'h0, count}, 64'h0);

    // Fill to full with the writeback stage stalled
    bus.deq_rdy = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      set_enq(1'b1, 32'(i * 32'h11), 3'd0, 2'd0);
      exp_q.push_back(32'(i * 32'h11));
      next();
    end
    check("full_count", {61'h0, count}, 64'h4);
    check("full_enq_rdy", {63'h0, bus.enq_rdy}, 64'h0);
    set_enq(1'b1, 32'h55, 3'd0, 2'd0);
    next();
    set_enq(1'b0, 32'h0, 3'd0, 2'd0);
    check("full_ignored_count", {61'h0, count}, 64'h4);
    check("full_head", {32'h0, bus.deq_msg_data}, 64'h11);
    bus.deq_rdy = 1'b1;
    for (int i = 0; i < 4; i++) next();
    check("drain_count", {61'h0, count}, 64'h0);
    check("drain_empty", 64'(exp_q.size()), 64'h0);
    check("drain_enq_rdy", {63'h0, bus.enq_rdy}, 64'h1);

    // Back-to-back enq and deq across pointer wrap
    for (int i = 0; i < 10; i++) begin
      set_enq(1'b1, 32'h100 + 32'(i), 3'd0, 2'd0);
      exp_q.push_back(32'h100 + 32'(i));
      @(negedge clk);
      if (i > 0) begin
`ifdef RISCV_DMEMQ_BYPASS_EN
        check("wrap_count", {61'h0, count}, 64'h0);
`else
        check("wrap_count", {61'h0, count}, 64'h1);
`endif
      end
      next();
    end
    set_enq(1'b0, 32'h0, 3'd0, 2'd0);
    next(); next();
    check("wrap_drained", 64'(exp_q.size()), 64'h0);

    // Flush with a simultaneous enqueue
    bus.deq_rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_enq(1'b1, 32'hA0 + 32'(i), 3'd0, 2'd0);
      exp_q.push_back(32'hA0 + 32'(i));
      next();
    end
    check("pre_flush_count", {61'h0, count}, 64'h3);
    flush = 1'b1;
    set_enq(1'b1, 32'h00000BAD, 3'd0, 2'd0);
    next();
    flush = 1'b0;
    set_enq(1'b0, 32'h0, 3'd0, 2'd0);
    exp_q.delete();
    check("flush_count", {61'h0, count}, 64'h0);
    check("flush_deq_val", {63'h0, bus.deq_val}, 64'h0);
    bus.deq_rdy = 1'b1;
    next(); next(); next();

    // Asynchronous reset mid-burst
    bus.deq_rdy = 1'b0;
    for (int i = 0; i < 2; i++) begin
      set_enq(1'b1, 32'hC0 + 32'(i), 3'd0, 2'd0);
      next();
    end
    set_enq(1'b0, 32'h0, 3'd0, 2'd0);
    check("pre_reset_count", {61'h0, count}, 64'h2);
    #2;
    reset = 1'b0;
    #1;
    check("async_rst_deq_val", {63'h0, bus.deq_val}, 64'h0);
    check("async_rst_count", {61'h0, count}, 64'h0);
    check("async_rst_data", {32'h0, bus.deq_msg_data}, 64'h0);
    @(negedge clk);
    reset = 1'b1;
    next();
    check("post_rst_enq_rdy", {63'h0, bus.enq_rdy}, 64'h1);
    check("post_rst_count", {61'h0, count}, 64'h0);

    // Empty-queue latency
    bus.deq_rdy = 1'b1;
    set_enq(1'b1, 32'hDEADBEEF, 3'd0, 2'd0);
    exp_q.push_back(32'hDEADBEEF);
    @(negedge clk);
`ifdef RISCV_DMEMQ_BYPASS_EN
    check("bypass_deq_val", {63'h0, bus.deq_val}, 64'h1);
    check("bypass_deq_data", {32'h0, bus.deq_msg_data}, 64'hDEADBEEF);
    next();
    set_enq(1'b0, 32'h0, 3'd0, 2'd0);
    check("bypass_count", {61'h0, count}, 64'h0);
`else
    check("latency_deq_val0", {63'h0, bus.deq_val}, 64'h0);
    next();
    set_enq(1'b0, 32'h0, 3'd0, 2'd0);
    @(negedge clk);
    check("latency_deq_val1", {63'h0, bus.deq_val}, 64'h1);
    check("latency_deq_data", {32'h0, bus.deq_msg_data}, 64'hDEADBEEF);
`endif
    next(); next();
    check("final_drained", 64'(exp_q.size()), 64'h0);
    check("final_count", {61'h0, count}, 64'h0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
